// File: rtl/pack_rq0_stream_ctrl.sv
// rtl/pack_rq0_stream_ctrl.sv - packs coefficients 0..N-2 of an Rq polynomial into a byte stream
// Optional feature macro: PACK_RQ_ABORT_EN (adds the abort input)
module pack_rq0_stream_ctrl #(
  parameter int N      = 701,
  parameter int COEF_W = 13,
  parameter int ADDR_W = 10,
  parameter int NBYTES = 1138
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef PACK_RQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic              coef_rd_en,
  output logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_rdata,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              byte_last
);

  localparam int BUF_W = COEF_W + 7;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int BC_W  = $clog2(NBYTES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 2);

  typedef enum logic [2:0] {IDLE, FILL, EMIT, FLUSH, DONE} state_t;

  state_t            state;
  logic [BUF_W-1:0]  bit_buf;
  logic [CNT_W-1:0]  cnt;
  logic              land;
  logic              reads_done;
  logic [BC_W-1:0]   byte_cnt;

  logic              active;
  logic              abort_req;
  logic              hs;
  logic [CNT_W-1:0]  cnt_pop;
  logic [BUF_W-1:0]  buf_pop;
  logic [CNT_W-1:0]  cnt_new;
  logic [BUF_W-1:0]  buf_new;
  logic [BC_W-1:0]   byte_cnt_new;
  logic              all_in;

`ifdef PACK_RQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  assign active = (state == FILL) || (state == EMIT) || (state == FLUSH);
  assign hs     = byte_valid & byte_ready;

  // The flush byte holds fewer than 8 valid bits, so popping it empties the buffer.
  assign cnt_pop = hs ? ((cnt > CNT_W'(8)) ? cnt - CNT_W'(8) : '0) : cnt;
  assign buf_pop = hs ? (bit_buf >> 8) : bit_buf;
  assign cnt_new = cnt_pop + (land ? CNT_W'(COEF_W) : '0);
  assign buf_new = buf_pop | (land ? (BUF_W'(coef_rdata) << cnt_pop) : '0);
  assign byte_cnt_new = byte_cnt + BC_W'(hs);

  // One read in flight at most; landing with fewer than 8 bits keeps 7+13 within the buffer.
  assign coef_rd_en = active && !abort_req && !land && !reads_done && (cnt_pop < CNT_W'(8));
  assign all_in     = reads_done && !coef_rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      coef_addr  <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
      bit_buf    <= '0;
      cnt        <= '0;
      land       <= 1'b0;
      reads_done <= 1'b0;
      byte_cnt   <= '0;
    end else if (active && abort_req) begin
      state      <= IDLE;
      busy       <= 1'b0;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
      bit_buf    <= '0;
      cnt        <= '0;
      land       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state      <= FILL;
            busy       <= 1'b1;
            coef_addr  <= '0;
            bit_buf    <= '0;
            cnt        <= '0;
            land       <= 1'b0;
            reads_done <= 1'b0;
            byte_cnt   <= '0;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          land     <= coef_rd_en;
          bit_buf  <= buf_new;
          cnt      <= cnt_new;
          byte_cnt <= byte_cnt_new;
          if (coef_rd_en) begin
            if (coef_addr == LAST_ADDR) reads_done <= 1'b1;
            else                        coef_addr  <= coef_addr + 1'b1;
          end
          byte_data <= rev8(buf_new[7:0]);
          if (cnt_new >= CNT_W'(8)) begin
            state      <= EMIT;
            byte_valid <= 1'b1;
            byte_last  <= (byte_cnt_new == BC_W'(NBYTES - 1));
          end else if (all_in && (cnt_new != '0)) begin
            state      <= FLUSH;
            byte_valid <= 1'b1;
            byte_last  <= (byte_cnt_new == BC_W'(NBYTES - 1));
          end else if (all_in) begin
            state      <= DONE;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
            byte_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            state      <= FILL;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pack_rq0_stream_ctrl.sv
// tb/tb_pack_rq0_stream_ctrl.sv - directed bench for pack_rq0_stream_ctrl
module tb_pack_rq0_stream_ctrl;

  localparam int NBYTES = 1138;
  localparam int NCOEF  = 700;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, coef_rd_en;
  logic [9:0]  coef_addr;
  logic [12:0] coef_rdata = '0;
  logic [7:0]  byte_data;
  logic        byte_valid, byte_last;
  logic        byte_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [12:0] mem [0:700];
  logic [7:0]  exp_b [0:NBYTES-1];

  bit   rand_ready = 0;
  bit   ready_level = 1;
  bit   clear_mon = 0;

  logic [7:0] cap_bytes[$];
  int   n_last, last_pos, done_cnt, max_addr, rd_cnt, stall_err;
  bit   prev_stall;
  logic [7:0] prev_data;

  pack_rq0_stream_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
`ifdef PACK_RQ_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .coef_rd_en (coef_rd_en),
    .coef_addr  (coef_addr),
    .coef_rdata (coef_rdata),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (coef_rd_en) coef_rdata <= mem[coef_addr];

  initial begin
    forever begin
      @(posedge clk);
      #1 byte_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  always @(negedge clk) begin
    if (clear_mon) begin
      cap_bytes.delete();
      n_last = 0; last_pos = -1; done_cnt = 0; max_addr = 0; rd_cnt = 0; stall_err = 0;
      prev_stall = 0;
    end else if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (byte_valid !== 1'b1 || byte_data !== prev_data)) stall_err++;
      if (byte_valid && byte_ready) begin
        cap_bytes.push_back(byte_data);
        if (byte_last) begin n_last++; last_pos = cap_bytes.size() - 1; end
      end
      if (done) done_cnt++;
      if (coef_rd_en) begin
        rd_cnt++;
        if (int'(coef_addr) > max_addr) max_addr = int'(coef_addr);
      end
      prev_stall = byte_valid && !byte_ready;
      prev_data  = byte_data;
    end
  end

  function automatic void build_gold();
    for (int m = 0; m < NBYTES; m++) begin
      logic [7:0] b;
      b = '0;
      for (int i = 0; i < 8; i++) begin
        int k;
        k = 8 * m + i;
        if (k < NCOEF * 13) b[7-i] = mem[k / 13][k % 13];
      end
      exp_b[m] = b;
    end
  endfunction

  task automatic clear_monitor();
    @(posedge clk); #1 clear_mon = 1;
    @(negedge clk); #1 clear_mon = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input int max_cyc, output int lat);
    lat = 1;
    while (done_cnt == 0 && lat < max_cyc) begin @(posedge clk); lat++; end
    repeat (3) @(posedge clk);
  endtask

  task automatic run_op(output int lat);
    clear_monitor();
    pulse_start();
    wait_done(6000, lat);
  endtask

  task automatic check_gold(input string name);
    int mism;
    mism = 0;
    checks++;
    if (cap_bytes.size() !== NBYTES) begin
      errors++; $display("FAIL %s_count: got %0d want %0d", name, cap_bytes.size(), NBYTES);
    end
    for (int m = 0; m < NBYTES && m < cap_bytes.size(); m++)
      if (cap_bytes[m] !== exp_b[m]) mism++;
    checks++;
    if (mism !== 0) begin errors++; $display("FAIL %s_bytes: %0d mismatching bytes want 0", name, mism); end
    checks++;
    if (n_last !== 1 || last_pos !== NBYTES - 1) begin
      errors++; $display("FAIL %s_last: count %0d pos %0d want 1 at %0d", name, n_last, last_pos, NBYTES - 1);
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL %s_done: got %0d pulses want 1", name, done_cnt); end
  endtask

  task automatic fill_zero();
    for (int j = 0; j <= 700; j++) mem[j] = '0;
  endtask

  task automatic fill_random();
    for (int j = 0; j <= 700; j++) mem[j] = 13'($urandom);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, coef_rd_en, byte_valid, byte_last} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {busy, done, coef_rd_en, byte_valid, byte_last});
    end
    checks++;
    if (coef_addr !== 10'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", coef_addr); end
    checks++;
    if (byte_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", byte_data); end
  endtask

  task automatic test_all_zero();
    int lat, nz;
    fill_zero();
    build_gold();
    run_op(lat);
    check_gold("zero");
    nz = 0;
    foreach (cap_bytes[i]) if (cap_bytes[i] !== 8'h00) nz++;
    checks++;
    if (nz !== 0) begin errors++; $display("FAIL zero_nonzero: got %0d want 0", nz); end
    checks++;
    if (max_addr > 699) begin errors++; $display("FAIL zero_max_addr: got %0d want <=699", max_addr); end
    checks++;
    if (lat > 2 * NBYTES + 5) begin errors++; $display("FAIL zero_latency: got %0d want <=%0d", lat, 2 * NBYTES + 5); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_single_bit();
    int lat;
    fill_zero();
    mem[0] = 13'h0001;
    run_op(lat);
    checks++;
    if (cap_bytes.size() < 2 || cap_bytes[0] !== 8'h80 || cap_bytes[1] !== 8'h00) begin
      errors++; $display("FAIL single_byte0: got %h want 80", cap_bytes.size() > 0 ? cap_bytes[0] : 8'hxx);
    end
    build_gold();
    check_gold("single");
  endtask

  task automatic test_full_coef();
    int lat;
    fill_zero();
    mem[0] = 13'h1FFF;
    run_op(lat);
    checks++;
    if (cap_bytes.size() < 3 || cap_bytes[0] !== 8'hFF || cap_bytes[1] !== 8'hF8 || cap_bytes[2] !== 8'h00) begin
      errors++; $display("FAIL fullcoef_bytes: size %0d want FF F8 00", cap_bytes.size());
    end
  endtask

  task automatic test_tail();
    int lat;
    fill_zero();
    mem[699] = 13'h1FFF;
    mem[700] = 13'h1FFF;
    run_op(lat);
    checks++;
    if (cap_bytes.size() !== NBYTES) begin
      errors++; $display("FAIL tail_count: got %0d want %0d", cap_bytes.size(), NBYTES);
    end else begin
      checks++;
      if (cap_bytes[1135] !== 8'h01) begin errors++; $display("FAIL tail_b1135: got %h want 01", cap_bytes[1135]); end
      checks++;
      if (cap_bytes[1136] !== 8'hFF) begin errors++; $display("FAIL tail_b1136: got %h want ff", cap_bytes[1136]); end
      checks++;
      if (cap_bytes[1137] !== 8'hF0) begin errors++; $display("FAIL tail_b1137: got %h want f0", cap_bytes[1137]); end
    end
    checks++;
    if (max_addr !== 699) begin errors++; $display("FAIL tail_max_addr: got %0d want 699", max_addr); end
  endtask

  task automatic test_random_ready();
    int lat;
    fill_random();
    build_gold();
    rand_ready = 1;
    run_op(lat);
    rand_ready = 0;
    check_gold("random");
    checks++;
    if (stall_err !== 0) begin errors++; $display("FAIL random_stable: got %0d changes want 0", stall_err); end
  endtask

  task automatic test_stall_and_busy_start();
    int lat;
    fill_random();
    build_gold();
    ready_level = 0;
    clear_monitor();
    pulse_start();
    repeat (200) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rd_cnt !== 1) begin errors++; $display("FAIL stall_reads: got %0d want 1", rd_cnt); end
    checks++;
    if (byte_valid !== 1'b1 || byte_data !== exp_b[0]) begin
      errors++; $display("FAIL stall_hold: valid %b data %h want 1 %h", byte_valid, byte_data, exp_b[0]);
    end
    pulse_start();
    ready_level = 1;
    wait_done(6000, lat);
    check_gold("stall");
    checks++;
    if (stall_err !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", stall_err); end
  endtask

  task automatic test_rst_mid();
    int lat, guard;
    fill_random();
    clear_monitor();
    pulse_start();
    guard = 0;
    while (cap_bytes.size() < 500 && guard < 3000) begin @(posedge clk); guard++; end
    checks++;
    if (cap_bytes.size() < 500) begin errors++; $display("FAIL rstmid_reach: got %0d bytes want 500", cap_bytes.size()); end
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    checks++;
    if ({busy, done, coef_rd_en, byte_valid, byte_last} !== 5'b0 || coef_addr !== 10'd0) begin
      errors++; $display("FAIL rstmid_state: flags %b addr %0d want 00000 0", {busy, done, coef_rd_en, byte_valid, byte_last}, coef_addr);
    end
    repeat (5) @(posedge clk);
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL rstmid_nodone: got %0d want 0", done_cnt); end
    fill_random();
    build_gold();
    run_op(lat);
    check_gold("rstmid");
  endtask

`ifdef PACK_RQ_ABORT_EN
  task automatic test_abort();
    int lat, guard;
    fill_random();
    clear_monitor();
    pulse_start();
    guard = 0;
    while (cap_bytes.size() < 500 && guard < 3000) begin @(posedge clk); guard++; end
    #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || byte_valid !== 1'b0) begin
      errors++; $display("FAIL abort_state: busy %b valid %b want 0 0", busy, byte_valid);
    end
    repeat (5) @(posedge clk);
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL abort_nodone: got %0d want 0", done_cnt); end
    build_gold();
    run_op(lat);
    check_gold("abort");
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_all_zero();
    test_single_bit();
    test_full_coef();
    test_tail();
    test_random_ready();
    test_stall_and_busy_start();
    test_rst_mid();
`ifdef PACK_RQ_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
